shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath (logical left / arithmetic right) between NUM_REQ requesters, e.g. ALU execute stage and the row-shift engine of the game logic.
- Round-robin arbitration, valid/ready handshake on every requester, single registered response slot with requester ID tag.
- Shift itself is combinational. The block adds arbitration, a result register and backpressure.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ID_W, 1, width of requester tag; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (grant)
- req_operand  in  NUM_REQ*32  operand, requester i at bits [32i+31:32i]
- req_shamt  in  NUM_REQ*5  shift amount, requester i at [5i+4:5i]
- req_arith  in  NUM_REQ  0 = logical left shift, 1 = arithmetic right shift
- resp_valid  out  1  result slot full
- resp_ready  in  1  consumer takes result
- resp_data  out  32  shifted result
- resp_id  out  ID_W  index of requester that produced resp_data

Behaviour:
- Reset: resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0, req_ready all 0 in the reset cycle.
- Reset mid-operation discards any held result; no partial handshake survives reset.
- States:
  - EMPTY (resp_valid=0)
  - FULL (resp_valid=1)
- can_accept = EMPTY | (FULL & resp_ready). Same-cycle drain-and-refill gives full throughput: one result per cycle.
- Grant rule:
  - When can_accept, grant the first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - Exactly one req_ready bit is high; it is combinational from req_valid, rr_ptr and state.
  - If not can_accept, or no valid request, all req_ready=0.
- On grant of i:
  - Next cycle resp_valid=1, resp_id=i.
  - resp_data = operand_i << shamt_i (zero fill) if arith=0, or operand_i >>> shamt_i (sign fill from bit 31) if arith=1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to resp_valid.
- Transitions:
  - FULL & resp_ready & no grant -> EMPTY.
  - FULL & ~resp_ready -> FULL, with data and id held stable.
- rr_ptr changes only on a grant.
- Requester protocol: requester must hold its operand, shamt and arith stable while req_valid=1 and req_ready=0. req_valid may not be withdrawn before acceptance.
- Shift amount 0 passes the operand unchanged. Shift amount 31: sll leaves only bit 0 in bit 31; sra gives 0x00000000 or 0xFFFFFFFF.
- Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,..,NUM_REQ-1,0 with no requester starved longer than NUM_REQ-1 grants.

Optional Feature:
- Macro SHIFT_ARBITER_STATS_EN.
- When defined, two extra outputs are added:
  - stat_grants (out, 32): number of accepted requests.
  - stat_conflicts (out, 32): cycles with at least 2 req_valid bits high or (any req_valid & ~can_accept).
  - Both reset to 0, increment by 1 per event, and wrap modulo 2^32.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - SHIFT_OP_SLL=1'b0, SHIFT_OP_SRA=1'b1
  - DATA_W=32, SHAMT_W=5
  - reset values of the response slot
- Sub-module shift_core: combinational 32-bit shifter with inputs operand, shamt, arith and output result.
  - It is built from the existing 16/8/4/2/1 staged left shifter and its arithmetic-right counterpart, with a 2:1 select on arith.
  - Arbitration and the register stay in shift_arbiter.

Test Plan:
- Reset, then req0 valid with operand 0x00000001, shamt 31, arith 0, resp_ready=1. Required: req_ready[0]=1 that cycle; next cycle resp_valid=1, resp_data=0x80000000, resp_id=0.
- req1 with operand 0x80000010, shamt 4, arith 1. Required: resp_data=0xF8000001, resp_id=1. Same operand with shamt 0 returns 0x80000010.
- Both requesters valid continuously, resp_ready=1 for 6 cycles. Required: resp_id sequence 0,1,0,1,0,1 with resp_valid high every cycle after the first.
- Hold resp_ready=0 for 3 cycles with both requesters valid. Required: all req_ready=0, and resp_data/resp_id unchanged across the stall. Then raise resp_ready: a new grant occurs in the same cycle as the drain.
- Assert reset while resp_valid=1 with a pending request. Required next cycle: resp_valid=0, rr_ptr=0, so the first grant after reset goes to requester 0.
- With SHIFT_ARBITER_STATS_EN, run the 6-cycle contention case. Required: stat_grants=6, stat_conflicts=6.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: operation encodings, datapath widths,
// response-slot states and their reset values.
package shift_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic SHIFT_OP_SLL = 1'b0;
  localparam logic SHIFT_OP_SRA = 1'b1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [0:0]        RESP_STATE_RST = ST_EMPTY;
  localparam logic [DATA_W-1:0] RESP_DATA_RST  = '0;

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit shifter: staged 16/8/4/2/1 logical-left and
// arithmetic-right networks with a final select on arith.
module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] w_l16, w_l8, w_l4, w_l2, w_l1;
  logic [DATA_W-1:0] w_r16, w_r8, w_r4, w_r2, w_r1;
  logic              w_sign;

  assign w_sign = operand[31];

  assign w_l16 = shamt[4] ? {operand[15:0], 16'h0000} : operand;
  assign w_l8  = shamt[3] ? {w_l16[23:0], 8'h00}      : w_l16;
  assign w_l4  = shamt[2] ? {w_l8[27:0], 4'h0}        : w_l8;
  assign w_l2  = shamt[1] ? {w_l4[29:0], 2'b00}       : w_l4;
  assign w_l1  = shamt[0] ? {w_l2[30:0], 1'b0}        : w_l2;

  assign w_r16 = shamt[4] ? {{16{w_sign}}, operand[31:16]} : operand;
  assign w_r8  = shamt[3] ? {{8{w_sign}}, w_r16[31:8]}     : w_r16;
  assign w_r4  = shamt[2] ? {{4{w_sign}}, w_r8[31:4]}      : w_r8;
  assign w_r2  = shamt[1] ? {{2{w_sign}}, w_r4[31:2]}      : w_r4;
  assign w_r1  = shamt[0] ? {w_sign, w_r2[31:1]}           : w_r2;

  always_comb begin
    result = w_l1;
    case (arith)
      SHIFT_OP_SLL: result = w_l1;
      SHIFT_OP_SRA: result = w_r1;
      default:      result = w_l1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core among NUM_REQ requesters, with a
// single registered response slot. Optional counters: SHIFT_ARBITER_STATS_EN.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_operand,
  input  logic [NUM_REQ*SHAMT_W-1:0]  req_shamt,
  input  logic [NUM_REQ-1:0]          req_arith,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic [ID_W-1:0]             resp_id
`ifdef SHIFT_ARBITER_STATS_EN
  ,
  output logic [31:0]                 stat_grants,
  output logic [31:0]                 stat_conflicts
`endif
);

  logic [0:0]         r_state;
  logic [DATA_W-1:0]  r_data;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_rr_ptr;

  logic               w_can_accept;
  logic               w_found;
  logic               w_grant;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W:0]      w_probe;
  logic [DATA_W-1:0]  w_operand;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_arith;
  logic [DATA_W-1:0]  w_result;

  // Search starts at r_rr_ptr; the extra probe bit handles wrap for
  // non-power-of-two NUM_REQ.
  always_comb begin
    w_can_accept = ~reset & ((r_state == ST_EMPTY) | resp_ready);
    w_found      = 1'b0;
    w_gnt_idx    = '0;
    w_probe      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_probe = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_probe >= (ID_W+1)'(NUM_REQ)) begin
        w_probe = w_probe - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[w_probe[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_probe[ID_W-1:0];
      end
    end
    w_grant = w_found & w_can_accept;
  end

  always_comb begin
    req_ready = '0;
    w_operand = '0;
    w_shamt   = '0;
    w_arith   = SHIFT_OP_SLL;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_operand    = req_operand[i*DATA_W +: DATA_W];
        w_shamt      = req_shamt[i*SHAMT_W +: SHAMT_W];
        w_arith      = req_arith[i];
        req_ready[i] = w_grant;
      end
    end
  end

  shift_core u_shift_core (
    .operand (w_operand),
    .shamt   (w_shamt),
    .arith   (w_arith),
    .result  (w_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= RESP_STATE_RST;
      r_data   <= RESP_DATA_RST;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_state  <= ST_FULL;
      r_data   <= w_result;
      r_id     <= w_gnt_idx;
      r_rr_ptr <= (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);
    end else if (resp_ready) begin
      r_state  <= ST_EMPTY;
    end
  end

  assign resp_valid = (r_state == ST_FULL);
  assign resp_data  = r_data;
  assign resp_id    = r_id;

`ifdef SHIFT_ARBITER_STATS_EN
  logic [31:0] r_stat_grants;
  logic [31:0] r_stat_conflicts;
  logic        w_conflict;

  assign w_conflict = ($countones(req_valid) >= 2) || ((|req_valid) && !w_can_accept);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat_grants    <= '0;
      r_stat_conflicts <= '0;
    end else begin
      if (w_grant)    r_stat_grants    <= r_stat_grants + 32'd1;
      if (w_conflict) r_stat_conflicts <= r_stat_conflicts + 32'd1;
    end
  end

  assign stat_grants    = r_stat_grants;
  assign stat_conflicts = r_stat_conflicts;
`endif

endmodule
